// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, two-flop row synchronizer, per-scan key
// capture and scan-level debounce, producing a stable key code and press strobe.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows_in,
  output logic [3:0] cols_out,
  output logic [7:0] cur_key,
  output logic       strobe
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_SCANS);

  logic [3:0]    rows_meta;
  logic [3:0]    rows_s;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [7:0]    acc;
  logic          invalid;
  logic [7:0]    cand;
  logic [CW-1:0] cnt;

  logic          sample;
  logic          end_scan;
  logic          multi_row;
  logic [7:0]    acc_nxt;
  logic          inv_nxt;
  logic [7:0]    raw;
  logic [7:0]    cand_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          accept;

  assign cols_out = 4'b1000 >> col_idx;

  // The end-of-scan evaluation folds in the column-3 sample taken in the same
  // cycle, so the raw code is built from the accumulator's next value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    acc_nxt   = acc;
    inv_nxt   = invalid;
    sample    = (dwell == DWELL_LAST);
    end_scan  = sample && (col_idx == 2'd3);
    multi_row = (rows_s & (rows_s - 4'd1)) != 4'd0;

    if (sample && (rows_s != 4'd0)) begin
      if (acc == 8'd0) acc_nxt = {rows_s, cols_out};
      else             inv_nxt = 1'b1;
      if (multi_row)   inv_nxt = 1'b1;
    end

    raw = inv_nxt ? 8'd0 : acc_nxt;

    if (raw == cand) begin
      cand_nxt = cand;
      cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end else begin
      cand_nxt = raw;
      cnt_nxt  = CW'(1);
    end

    accept = (cnt_nxt == CNT_MAX) && (cand_nxt != cur_key);
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; reset is synchronous and clears every flop here.
    if (rst) begin
      rows_meta <= 4'd0;
      rows_s    <= 4'd0;
      dwell     <= '0;
      col_idx   <= 2'd0;
      acc       <= 8'd0;
      invalid   <= 1'b0;
      cand      <= 8'd0;
      cnt       <= '0;
      cur_key   <= 8'd0;
      strobe    <= 1'b0;
    end else begin
      rows_meta <= rows_in;
      rows_s    <= rows_meta;
      strobe    <= 1'b0;

      if (sample) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
      end else begin
        dwell   <= dwell + DW'(1);
      end

      if (end_scan) begin
        acc     <= 8'd0;
        invalid <= 1'b0;
        cand    <= cand_nxt;
        cnt     <= cnt_nxt;
        if (accept) begin
          cur_key <= cand_nxt;
          strobe  <= (cand_nxt != 8'd0);
        end
      end else begin
        acc     <= acc_nxt;
        invalid <= inv_nxt;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives the rows,
// and a per-scan run-length reference model predicts cur_key / strobe.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_LEN = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rows_in;
  logic [3:0] cols_out;
  logic [7:0] cur_key;
  logic       strobe;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk      (clk),
    .rst      (rst),
    .rows_in  (rows_in),
    .cols_out (cols_out),
    .cur_key  (cur_key),
    .strobe   (strobe)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  int          n;
  int          strobes_seen;
  logic [15:0] pressed;
  logic [7:0]  hist[$];
  logic [7:0]  exp_key;
  logic        exp_strobe;

  function automatic logic [7:0] key_code(int r, int c);
    logic [3:0] one = 4'b1000;
    return {one >> r, one >> c};
  endfunction

  function automatic logic [15:0] key_bit(int r, int c);
    logic [15:0] b = 16'd1;
    return b << (r * 4 + c);
  endfunction

  // A scan yields a key only when exactly one switch in the matrix is closed.
  function automatic logic [7:0] scan_code(logic [15:0] p);
    if ($countones(p) != 1) return 8'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (p[r*4+c]) return key_code(r, c);
    return 8'd0;
  endfunction

  function automatic logic [3:0] keypad(logic [15:0] p, logic [3:0] cols);
    logic [3:0] rows = 4'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (cols[3-c] && p[r*4+c]) rows[3-r] = 1'b1;
    return rows;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Accept when the last DEB scans all produced the same code and it differs
  // from the currently presented key.
  task automatic model_scan_end();
    logic [7:0] raw;
    logic       same;
    raw = scan_code(pressed);
    hist.push_back(raw);
    if (hist.size() > DEB) void'(hist.pop_front());
    same = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != raw) same = 1'b0;
    if (same && raw != exp_key) begin
      exp_key    = raw;
      exp_strobe = (raw != 8'd0);
    end
  endtask

  task automatic tick();
    logic [3:0] one = 4'b1000;
    @(posedge clk);
    n++;
    exp_strobe = 1'b0;
    if (n % SCAN_LEN == 0) model_scan_end();
    @(negedge clk);
    rows_in = keypad(pressed, cols_out);
    if (strobe === 1'b1) strobes_seen++;
    check("cols_out", {4'd0, cols_out}, {4'd0, one >> ((n / SCAN_DIV) % 4)});
    check("cur_key", cur_key, exp_key);
    check("strobe", {7'd0, strobe}, {7'd0, exp_strobe});
  endtask

  task automatic ticks(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic set_keys(logic [15:0] p);
    pressed = p;
    rows_in = keypad(pressed, cols_out);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_cols", {4'd0, cols_out}, 8'b0000_1000);
    check("rst_key", cur_key, 8'd0);
    check("rst_strobe", {7'd0, strobe}, 8'd0);
    rst        = 1'b0;
    n          = 0;
    exp_key    = 8'd0;
    exp_strobe = 1'b0;
    hist.delete();
    rows_in = keypad(pressed, cols_out);
  endtask

  initial begin
    logic [15:0] p;
    int          mode;
    rst        = 1'b1;
    rows_in    = 4'd0;
    pressed    = 16'd0;
    exp_key    = 8'd0;
    exp_strobe = 1'b0;
    n          = 0;

    // 1: reset, no key
    do_reset();
    strobes_seen = 0;
    ticks(4 * SCAN_LEN);
    check("s1_strobes", 8'(strobes_seen), 8'd0);

    // 2: hold R2 C0 for 10 scans, then release
    strobes_seen = 0;
    set_keys(key_bit(2, 0));
    ticks(2 * SCAN_LEN);
    check("s2_early", cur_key, 8'd0);
    ticks(SCAN_LEN);
    check("s2_accept", cur_key, 8'b0010_1000);
    check("s2_strobe", {7'd0, strobe}, 8'd1);
    ticks(7 * SCAN_LEN);
    check("s2_held_strobes", 8'(strobes_seen), 8'd1);
    set_keys(16'd0);
    ticks(2 * SCAN_LEN);
    check("s2_rel_early", cur_key, 8'b0010_1000);
    ticks(SCAN_LEN);
    check("s2_released", cur_key, 8'd0);
    check("s2_strobes", 8'(strobes_seen), 8'd1);

    // 3: bounce R3 C0 on alternate scans, then hold
    strobes_seen = 0;
    for (int i = 0; i < 3; i++) begin
      set_keys(key_bit(3, 0)); ticks(SCAN_LEN);
      set_keys(16'd0);         ticks(SCAN_LEN);
    end
    check("s3_bounce_strobes", 8'(strobes_seen), 8'd0);
    set_keys(key_bit(3, 0));
    ticks(2 * SCAN_LEN);
    check("s3_early", cur_key, 8'd0);
    ticks(SCAN_LEN);
    check("s3_accept", cur_key, 8'b0001_1000);
    check("s3_strobes", 8'(strobes_seen), 8'd1);

    // 4: two keys at once, then release one
    set_keys(16'd0);
    ticks(3 * SCAN_LEN);
    strobes_seen = 0;
    set_keys(key_bit(0, 1) | key_bit(1, 2));
    ticks(5 * SCAN_LEN);
    check("s4_dual_key", cur_key, 8'd0);
    check("s4_dual_strobes", 8'(strobes_seen), 8'd0);
    set_keys(key_bit(0, 1));
    ticks(3 * SCAN_LEN);
    check("s4_accept", cur_key, 8'b1000_0100);
    check("s4_strobes", 8'(strobes_seen), 8'd1);

    // 5: direct change R1 C1 -> R2 C2
    strobes_seen = 0;
    set_keys(key_bit(1, 1));
    ticks(3 * SCAN_LEN);
    check("s5_first", cur_key, 8'b0100_0100);
    set_keys(key_bit(2, 2));
    ticks(3 * SCAN_LEN);
    check("s5_second", cur_key, 8'b0010_0010);
    check("s5_strobes", 8'(strobes_seen), 8'd2);

    // 6: reset mid-debounce while holding R0 C2
    set_keys(16'd0);
    ticks(3 * SCAN_LEN);
    set_keys(key_bit(0, 2));
    ticks(2 * SCAN_LEN + 5);
    do_reset();
    strobes_seen = 0;
    ticks(2 * SCAN_LEN);
    check("s6_early", cur_key, 8'd0);
    ticks(SCAN_LEN);
    check("s6_accept", cur_key, 8'b1000_0010);
    check("s6_strobes", 8'(strobes_seen), 8'd1);

    // Randomized key patterns, hold lengths and occasional mid-scan resets
    for (int it = 0; it < 30; it++) begin
      mode = int'($urandom_range(0, 3));
      p    = 16'd0;
      if (mode >= 1)
        p = key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (mode == 3)
        p = p | key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      set_keys(p);
      ticks(int'($urandom_range(1, 4)) * SCAN_LEN);
      if (it % 10 == 9) begin
        ticks(int'($urandom_range(1, SCAN_LEN - 1)));
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
